// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module  : uart_pkg
// Brief   : Shared types and constants for the UART transmit buffer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } txbuf_state_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : sync_fifo
// Brief   : Single-clock circular-buffer FIFO with registered occupancy count.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int c_PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Flags decode the count register only, so nothing here depends on wr_en.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = wr_en && !w_full;
  assign w_pop   = rd_en && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffer.sv
//------------------------------------------------------------------------------
// Module  : uart_tx_buffer
// Brief   : Byte FIFO feeding a UART transmitter one frame at a time.
//           Optional overflow flag with ports ovf_clr/overflow under
//           UART_TXBUF_OVERFLOW_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [CNT_W-1:0]       count,
  output logic                   transmit,
  output logic [UART_DATA_W-1:0] tx_byte,
  input  logic                   is_transmitting,
  output logic                   busy
`ifdef UART_TXBUF_OVERFLOW_EN
  ,
  input  logic                   ovf_clr,
  output logic                   overflow
`endif
);

  txbuf_state_t           r_state;
  txbuf_state_t           w_state_next;
  logic                   w_pop;
  logic                   w_full;
  logic                   w_empty;
  logic [UART_DATA_W-1:0] w_head;
  logic                   r_transmit;
  logic [UART_DATA_W-1:0] r_tx_byte;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (UART_DATA_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (count)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = LAUNCH;
        end
      end
      LAUNCH:    w_state_next = WAIT_BUSY;
      WAIT_BUSY: if (is_transmitting)  w_state_next = WAIT_DONE;
      WAIT_DONE: if (!is_transmitting) w_state_next = IDLE;
      default:   w_state_next = IDLE;
    endcase
  end

  // transmit is registered from the next-state decode so it is high exactly
  // while the state register holds LAUNCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_transmit <= 1'b0;
      r_tx_byte  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_transmit <= (w_state_next == LAUNCH);
      if (w_pop) begin
        r_tx_byte <= w_head;
      end
    end
  end

`ifdef UART_TXBUF_OVERFLOW_EN
  logic r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (wr_en && w_full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`endif

  assign full     = w_full;
  assign empty    = w_empty;
  assign transmit = r_transmit;
  assign tx_byte  = r_tx_byte;
  assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
//------------------------------------------------------------------------------
// Module  : tb_uart_tx_buffer
// Brief   : Self-checking bench for uart_tx_buffer with a behavioural UART.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] count;
  logic             transmit;
  logic [7:0]       tx_byte;
  logic             is_transmitting;
  logic             busy;
`ifdef UART_TXBUF_OVERFLOW_EN
  logic             ovf_clr;
  logic             overflow;
`endif

  uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .full            (full),
    .empty           (empty),
    .count           (count),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .is_transmitting (is_transmitting),
    .busy            (busy)
`ifdef UART_TXBUF_OVERFLOW_EN
    ,
    .ovf_clr         (ovf_clr),
    .overflow        (overflow)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: bytes accepted into the FIFO, frames launched, bytes seen.
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int accepted  = 0;
  int launches  = 0;
  int dropped   = 0;
  int pulse_err = 0;
  int stable_err = 0;
  int frame_len = 12;

  // Behavioural UART: raises is_transmitting 0..2 cycles after a launch and
  // holds it for frame_len cycles; a reset aborts the frame.
  bit         pend;
  bit         prev_tx;
  int         lead;
  int         frame;
  logic [7:0] cur;

  initial begin
    is_transmitting = 1'b0;
    pend = 0; prev_tx = 0; lead = 0; frame = 0; cur = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        is_transmitting = 1'b0;
        pend = 0;
        prev_tx = 0;
      end else begin
        if (transmit) begin
          if (prev_tx) pulse_err++;
          rx_q.push_back(tx_byte);
          launches++;
          cur   = tx_byte;
          pend  = 1;
          lead  = $urandom_range(0, 2);
          frame = frame_len;
        end else if (pend) begin
          if (lead > 0) lead--;
          else begin
            is_transmitting = 1'b1;
            pend = 0;
          end
        end else if (is_transmitting) begin
          if (frame > 0) frame--;
          else is_transmitting = 1'b0;
        end
        if (!transmit && busy && tx_byte !== cur) stable_err++;
        prev_tx = transmit;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (accepted - launches < DEPTH) begin
      exp_q.push_back(b);
      accepted++;
    end else begin
      dropped++;
    end
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (launches == accepted && !busy && !is_transmitting && !pend) begin
        ok = 1;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic clear_model();
    exp_q.delete();
    rx_q.delete();
    accepted = 0;
    launches = 0;
    dropped  = 0;
  endtask

  task automatic test_reset();
    step();
    tests++; if (count !== '0)    begin fails++; $display("FAIL reset_count: got %0d expected 0", count); end
    tests++; if (empty !== 1'b1)  begin fails++; $display("FAIL reset_empty: got %b expected 1", empty); end
    tests++; if (full !== 1'b0)   begin fails++; $display("FAIL reset_full: got %b expected 0", full); end
    tests++; if (transmit !== 1'b0) begin fails++; $display("FAIL reset_transmit: got %b expected 0", transmit); end
    tests++; if (tx_byte !== 8'h00) begin fails++; $display("FAIL reset_tx_byte: got %h expected 00", tx_byte); end
    tests++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef UART_TXBUF_OVERFLOW_EN
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
`endif
    rst = 1'b0;
    step();
    step();
    tests++; if (busy !== 1'b0 || transmit !== 1'b0) begin
      fails++; $display("FAIL reset_idle: busy %b transmit %b expected 0 0", busy, transmit);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_model();
    push(8'hA5);
    tests++; if (transmit !== 1'b0 || count !== CNT_W'(1)) begin
      fails++; $display("FAIL single_edge_k: transmit %b count %0d expected 0 1", transmit, count);
    end
    step();
    tests++; if (transmit !== 1'b1 || tx_byte !== 8'hA5 || busy !== 1'b1 || count !== '0) begin
      fails++; $display("FAIL single_launch: transmit %b tx_byte %h busy %b count %0d expected 1 a5 1 0",
                        transmit, tx_byte, busy, count);
    end
    step();
    tests++; if (transmit !== 1'b0) begin fails++; $display("FAIL single_pulse_width: got %b expected 0", transmit); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL single_timeout: got busy %b expected idle", busy); end
    tests++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      fails++; $display("FAIL single_rx: got %0d frames first %h expected 1 frame a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
    tests++; if (busy !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL single_end: busy %b empty %b expected 0 1", busy, empty);
    end
  endtask

  task automatic test_burst();
    bit ok;
    int peak = 0;
    clear_model();
    for (int i = 1; i <= 4; i++) begin
      push(8'(i));
      if (int'(count) > peak) peak = int'(count);
      tests++; if (count !== CNT_W'(accepted - launches)) begin
        fails++; $display("FAIL burst_count: got %0d expected %0d", count, accepted - launches);
      end
    end
    tests++; if (peak != 3) begin fails++; $display("FAIL burst_peak: got %0d expected 3", peak); end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL burst_timeout: got busy %b expected idle", busy); end
    tests++; if (rx_q.size() != 4) begin fails++; $display("FAIL burst_len: got %0d expected 4", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      tests++; if (rx_q[i] !== 8'(i + 1)) begin
        fails++; $display("FAIL burst_order[%0d]: got %h expected %h", i, rx_q[i], 8'(i + 1));
      end
    end
    tests++; if (empty !== 1'b1) begin fails++; $display("FAIL burst_empty: got %b expected 1", empty); end
  endtask

  task automatic test_full();
    bit ok;
    clear_model();
    frame_len = 20;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    tests++; if (dropped != 1 || accepted != DEPTH + 1) begin
      fails++; $display("FAIL full_model: got %0d accepted %0d dropped expected %0d 1", accepted, dropped, DEPTH + 1);
    end
    tests++; if (full !== 1'b1 || count !== CNT_W'(DEPTH)) begin
      fails++; $display("FAIL full_flag: full %b count %0d expected 1 %0d", full, count, DEPTH);
    end
`ifdef UART_TXBUF_OVERFLOW_EN
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_ovf_set: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    push(8'($urandom));
    ovf_clr = 1'b0;
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_ovf_set_wins: got %b expected 1", overflow); end
    step();
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL full_ovf_hold: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_ovf_clr: got %b expected 0", overflow); end
`endif
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL full_timeout: got busy %b expected idle", busy); end
    tests++; if (rx_q.size() != exp_q.size()) begin
      fails++; $display("FAIL full_len: got %0d expected %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      tests++; if (rx_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL full_order[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_model();
    for (int n = 0; n < 40; n++) begin
      frame_len = $urandom_range(1, 8);
      for (int w = 0; w < 200 && (accepted - launches) >= DEPTH; w++) step();
      repeat ($urandom_range(0, 3)) step();
      push(8'($urandom));
      tests++; if (count !== CNT_W'(accepted - launches) || full !== (accepted - launches == DEPTH)) begin
        fails++; $display("FAIL wrap_count: count %0d full %b expected %0d %b",
                          count, full, accepted - launches, (accepted - launches == DEPTH));
      end
    end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL wrap_timeout: got busy %b expected idle", busy); end
    tests++; if (rx_q.size() != 40 || dropped != 0) begin
      fails++; $display("FAIL wrap_len: got %0d frames %0d dropped expected 40 0", rx_q.size(), dropped);
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      tests++; if (rx_q[i] !== exp_q[i]) begin
        fails++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] a;
    logic [7:0] b;
    clear_model();
    frame_len = 6;
    a = 8'($urandom);
    b = 8'($urandom);
    push(a);
    push(b);
    tests++; if (count !== CNT_W'(1) || tx_byte !== a || transmit !== 1'b1) begin
      fails++; $display("FAIL simul_pushpop: count %0d tx_byte %h transmit %b expected 1 %h 1", count, tx_byte, transmit, a);
    end
    wait_idle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL simul_timeout: got busy %b expected idle", busy); end
    tests++; if (rx_q.size() != 2 || rx_q[0] !== a || rx_q[1] !== b) begin
      fails++; $display("FAIL simul_order: got %0d frames expected %h then %h", rx_q.size(), a, b);
    end
    tests++; if (pulse_err != 0 || stable_err != 0) begin
      fails++; $display("FAIL protocol: got %0d long pulses %0d unstable bytes expected 0 0", pulse_err, stable_err);
    end
  endtask

  task automatic test_reset_midframe();
    bit seen = 0;
    int launched;
    clear_model();
    frame_len = 20;
    for (int i = 0; i < 4; i++) push(8'($urandom));
    for (int i = 0; i < 50 && !seen; i++) begin
      if (is_transmitting) seen = 1;
      else step();
    end
    step();
    step();
    tests++; if (!seen || count !== CNT_W'(3) || busy !== 1'b1) begin
      fails++; $display("FAIL midframe_setup: seen %b count %0d busy %b expected 1 3 1", seen, count, busy);
    end
    launched = launches;
    rst = 1'b1;
    #1;
    tests++; if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || transmit !== 1'b0 ||
                 tx_byte !== 8'h00 || busy !== 1'b0) begin
      fails++; $display("FAIL midframe_reset: count %0d empty %b full %b transmit %b tx_byte %h busy %b expected 0 1 0 0 00 0",
                        count, empty, full, transmit, tx_byte, busy);
    end
    step();
    step();
    rst = 1'b0;
    accepted = launches;
    repeat (30) step();
    tests++; if (launches != launched || busy !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL midframe_after: launches %0d busy %b empty %b expected %0d 0 1", launches, busy, empty, launched);
    end
  endtask

  initial begin
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
`ifdef UART_TXBUF_OVERFLOW_EN
    ovf_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_wrap();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
